// File: rtl/mem_arbiter_rv32.sv
// Two-port (fetch/data) arbiter onto a single req/ack memory bus, data priority with fetch anti-starvation.
// Optional bus watchdog abort is compiled in when ARB_TIMEOUT_EN is defined.
module mem_arbiter_rv32 #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_LIM = 4,
    parameter int MAX_WAIT   = 15
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iIREQ,
    input  logic [AW-1:0] iIADDR,
    output logic [DW-1:0] oIDATA,
    output logic          oIACK,
    output logic          oStallI,
    input  logic          iDREQ,
    input  logic          iDRW,
    input  logic [AW-1:0] iDADDR,
    input  logic [DW-1:0] iDWDATA,
    output logic [DW-1:0] oDDATA,
    output logic          oDACK,
    output logic          oStallD,
    output logic          oBusREQ,
    output logic          oBusRW,
    output logic [AW-1:0] oBusADDR,
    output logic [DW-1:0] oBusWDATA,
    input  logic [DW-1:0] iBusRDATA,
    input  logic          iBusACK,
    output logic          oBusERR
);

    typedef enum logic [1:0] {S_IDLE, S_BUS_I, S_BUS_D} state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

    state_t        state_q, state_d;
    logic [3:0]    starve_q, starve_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_rw_q, bus_rw_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [DW-1:0] bus_wdata_q, bus_wdata_d;
    logic          iack_q, iack_d;
    logic          dack_q, dack_d;
    logic [DW-1:0] idata_q, idata_d;
    logic [DW-1:0] ddata_q, ddata_d;
    logic          err_q, err_d;

    logic in_bus, starved, grant_i, grant_d, bus_done, bus_abort;

    assign in_bus   = (state_q != S_IDLE);
    assign starved  = (starve_q == STARVE_MAX);
    assign grant_d  = (state_q == S_IDLE) && iDREQ && !(iIREQ && starved);
    assign grant_i  = (state_q == S_IDLE) && iIREQ && !grant_d;
    assign bus_done = in_bus && iBusACK;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [7:0] wait_q, wait_d;

    // Counts bus cycles of the current transaction; an ACK in the final cycle still wins.
    assign wait_d    = in_bus ? wait_q + 8'd1 : 8'd0;
    assign bus_abort = in_bus && !iBusACK && (wait_q == WAIT_LAST);

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            wait_q <= 8'd0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^8'(MAX_WAIT);
    assign bus_abort  = 1'b0;
`endif

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant_d) begin
                    state_d = S_BUS_D;
                end else if (grant_i) begin
                    state_d = S_BUS_I;
                end
            end
            S_BUS_I, S_BUS_D: begin
                if (bus_done || bus_abort) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus_req_d   = bus_req_q;
        bus_rw_d    = bus_rw_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        starve_d    = starve_q;
        idata_d     = idata_q;
        ddata_d     = ddata_q;
        iack_d      = 1'b0;
        dack_d      = 1'b0;
        err_d       = 1'b0;

        if (grant_d) begin
            bus_req_d   = 1'b1;
            bus_rw_d    = iDRW;
            bus_addr_d  = iDADDR;
            bus_wdata_d = iDWDATA;
            if (iIREQ && !starved) begin
                starve_d = starve_q + 4'd1;
            end
        end else if (grant_i) begin
            bus_req_d   = 1'b1;
            bus_rw_d    = 1'b1;
            bus_addr_d  = iIADDR;
            bus_wdata_d = '0;
            starve_d    = 4'd0;
        end

        if (bus_done) begin
            bus_req_d = 1'b0;
            if (state_q == S_BUS_I) begin
                iack_d  = 1'b1;
                idata_d = iBusRDATA;
            end else begin
                dack_d = 1'b1;
                if (bus_rw_q) begin
                    ddata_d = iBusRDATA;
                end
            end
        end else if (bus_abort) begin
            bus_req_d = 1'b0;
            err_d     = 1'b1;
            if (state_q == S_BUS_I) begin
                iack_d  = 1'b1;
                idata_d = '0;
            end else begin
                dack_d  = 1'b1;
                ddata_d = '0;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            starve_q    <= 4'd0;
            bus_req_q   <= 1'b0;
            bus_rw_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            iack_q      <= 1'b0;
            dack_q      <= 1'b0;
            idata_q     <= '0;
            ddata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            bus_req_q   <= bus_req_d;
            bus_rw_q    <= bus_rw_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            iack_q      <= iack_d;
            dack_q      <= dack_d;
            idata_q     <= idata_d;
            ddata_q     <= ddata_d;
            err_q       <= err_d;
        end
    end

    assign oIDATA    = idata_q;
    assign oIACK     = iack_q;
    assign oDDATA    = ddata_q;
    assign oDACK     = dack_q;
    assign oBusREQ   = bus_req_q;
    assign oBusRW    = bus_rw_q;
    assign oBusADDR  = bus_addr_q;
    assign oBusWDATA = bus_wdata_q;
    assign oBusERR   = err_q;
    // Stall tracks the raw request, released in the cycle the registered ACK is shown.
    assign oStallI   = iIREQ & ~iack_q;
    assign oStallD   = iDREQ & ~dack_q;

endmodule

// File: tb/tb_mem_arbiter_rv32.sv
// Bench for mem_arbiter_rv32: table of single transactions plus hand sequences for
// starvation, mid-transaction drop, stray ACK, async reset and (with ARB_TIMEOUT_EN) timeout.
module tb_mem_arbiter_rv32;

    logic        iCLK, iRST;
    logic        iIREQ, iDREQ, iDRW;
    logic [31:0] iIADDR, iDADDR, iDWDATA, iBusRDATA;
    logic        iBusACK;
    logic [31:0] oIDATA, oDDATA, oBusADDR, oBusWDATA;
    logic        oIACK, oStallI, oDACK, oStallD, oBusREQ, oBusRW, oBusERR;

    mem_arbiter_rv32 dut (
        .iCLK(iCLK), .iRST(iRST),
        .iIREQ(iIREQ), .iIADDR(iIADDR), .oIDATA(oIDATA), .oIACK(oIACK), .oStallI(oStallI),
        .iDREQ(iDREQ), .iDRW(iDRW), .iDADDR(iDADDR), .iDWDATA(iDWDATA),
        .oDDATA(oDDATA), .oDACK(oDACK), .oStallD(oStallD),
        .oBusREQ(oBusREQ), .oBusRW(oBusRW), .oBusADDR(oBusADDR), .oBusWDATA(oBusWDATA),
        .iBusRDATA(iBusRDATA), .iBusACK(iBusACK), .oBusERR(oBusERR)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return (a == 32'h100) ? 32'h13 : a + 32'h1111_0000;
    endfunction

    // Memory model: acks after mem_wait extra cycles of oBusREQ; force_ack injects a stray ACK.
    int   mem_wait = 0;
    logic mem_ack = 1'b0;
    logic force_ack = 1'b0;
    assign iBusACK = mem_ack | force_ack;

    initial begin
        int busy;
        busy = 0;
        iBusRDATA = 32'h0;
        forever begin
            @(posedge iCLK); #1;
            if (oBusREQ) begin
                mem_ack = (busy == mem_wait);
                if (busy == mem_wait) iBusRDATA = mem_rd(oBusADDR);
                busy++;
            end else begin
                busy = 0;
                mem_ack = 1'b0;
            end
        end
    end

    // Scoreboard: expected completions pushed at request, popped on each ACK pulse.
    typedef struct { logic [31:0] data; logic err; } exp_t;
    exp_t i_sb[$];
    exp_t d_sb[$];

    initial begin
        exp_t e;
        forever begin
            @(posedge iCLK); #1;
            if (oIACK) begin
                chk("i_ack_pending", 32'(i_sb.size() != 0), 32'd1);
                if (i_sb.size() != 0) begin
                    e = i_sb.pop_front();
                    chk("i_data", oIDATA, e.data);
                    chk("i_err", 32'(oBusERR), 32'(e.err));
                    $display("txn I ack data=%h err=%0d", oIDATA, oBusERR);
                end
            end
            if (oDACK) begin
                chk("d_ack_pending", 32'(d_sb.size() != 0), 32'd1);
                if (d_sb.size() != 0) begin
                    e = d_sb.pop_front();
                    chk("d_data", oDDATA, e.data);
                    chk("d_err", 32'(oBusERR), 32'(e.err));
                    $display("txn D ack data=%h err=%0d", oDDATA, oBusERR);
                end
            end
        end
    end

    typedef struct {
        logic        port;   // 1 = data, 0 = fetch
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wait_c;
        logic [31:0] rdata;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] ddata_m = 32'h0;

    task automatic run_txn(input vec_t v, input int idx);
        logic        seen, held_ok, stall_ok, ack, stall, exp_rw;
        logic [31:0] exp_d;
        int          lat;
        seen = 1'b0; held_ok = 1'b1; stall_ok = 1'b1; lat = 0;
        exp_rw = v.port ? v.rw : 1'b1;
        @(posedge iCLK); #1;
        mem_wait = v.wait_c;
        if (v.port) begin
            iDREQ = 1'b1; iDRW = v.rw; iDADDR = v.addr; iDWDATA = v.wdata;
            exp_d = v.rw ? v.rdata : ddata_m;
            d_sb.push_back('{exp_d, 1'b0});
            ddata_m = exp_d;
        end else begin
            iIREQ = 1'b1; iIADDR = v.addr;
            i_sb.push_back('{v.rdata, 1'b0});
        end
        #1;
        chk($sformatf("v%0d_stall_req", idx), 32'(v.port ? oStallD : oStallI), 32'd1);
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(posedge iCLK); #1;
            if (n == 1) begin
                chk($sformatf("v%0d_busreq", idx), 32'(oBusREQ), 32'd1);
                chk($sformatf("v%0d_busrw", idx), 32'(oBusRW), 32'(exp_rw));
                chk($sformatf("v%0d_busaddr", idx), oBusADDR, v.addr);
                if (!exp_rw) chk($sformatf("v%0d_buswdata", idx), oBusWDATA, v.wdata);
            end
            ack   = v.port ? oDACK : oIACK;
            stall = v.port ? oStallD : oStallI;
            if (ack) begin
                seen = 1'b1;
                lat  = n;
                chk($sformatf("v%0d_stall_ack", idx), 32'(stall), 32'd0);
                iIREQ = 1'b0; iDREQ = 1'b0;
            end else begin
                if (!stall) stall_ok = 1'b0;
                if (!(oBusREQ && oBusADDR == v.addr && oBusRW == exp_rw &&
                      (exp_rw || oBusWDATA == v.wdata))) held_ok = 1'b0;
            end
        end
        chk($sformatf("v%0d_ack_seen", idx), 32'(seen), 32'd1);
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.wait_c + 2));
        chk($sformatf("v%0d_bus_held", idx), 32'(held_ok), 32'd1);
        chk($sformatf("v%0d_stall_held", idx), 32'(stall_ok), 32'd1);
        $display("txn v%0d port=%s rw=%0d addr=%h latency=%0d", idx, v.port ? "D" : "I", v.rw, v.addr, lat);
    endtask

    initial begin
        logic        seen, bad, got;
        logic        exp_grant[10];
        int          grants, lat;
        logic        prev_req;

        iRST = 1'b0;
        iIREQ = 1'b0; iDREQ = 1'b0; iDRW = 1'b0;
        iIADDR = 32'h0; iDADDR = 32'h0; iDWDATA = 32'h0;

        vecs[0] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0,         1, 32'h0000_0013};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0204, 32'h0,         0, 32'h1111_0204};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 2, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_2000, 32'h0,         0, 32'h1111_2000};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_0010, 32'h0,         3, 32'h1111_0010};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0300, 32'h1234_5678, 0, 32'h0};
        exp_grant = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        repeat (2) @(posedge iCLK);
        #1;
        chk("rst_bus", {oBusADDR[29:0], oBusREQ, oBusRW}, 32'h0);
        chk("rst_wdata", oBusWDATA, 32'h0);
        chk("rst_data", oIDATA | oDDATA, 32'h0);
        chk("rst_flags", 32'({oIACK, oDACK, oStallI, oStallD, oBusERR}), 32'h0);
        iRST = 1'b1;

        for (int v = 0; v < 6; v++) run_txn(vecs[v], v);

        // Requester withdraws iDREQ mid-transaction; completion must still pulse.
        @(posedge iCLK); #1;
        mem_wait = 3;
        iDREQ = 1'b1; iDRW = 1'b1; iDADDR = 32'h44;
        d_sb.push_back('{32'h1111_0044, 1'b0});
        ddata_m = 32'h1111_0044;
        seen = 1'b0; lat = 0;
        for (int n = 1; n <= 30 && !seen; n++) begin
            @(posedge iCLK); #1;
            if (n == 2) iDREQ = 1'b0;
            if (oDACK) begin seen = 1'b1; lat = n; end
        end
        chk("drop_ack_seen", 32'(seen), 32'd1);
        chk("drop_latency", 32'(lat), 32'd5);
        $display("txn drop-mid D latency=%0d", lat);

        // Stray ACK while idle must be ignored.
        @(posedge iCLK); #1;
        force_ack = 1'b1;
        @(posedge iCLK); #1;
        force_ack = 1'b0;
        chk("stray_ack_idle", 32'({oBusREQ, oIACK, oDACK}), 32'h0);
        $display("txn stray ACK in idle");

        // Both ports requesting continuously with 0-wait memory.
        @(posedge iCLK); #1;
        mem_wait = 0;
        iIREQ = 1'b1; iIADDR = 32'h1000;
        iDREQ = 1'b1; iDRW = 1'b1; iDADDR = 32'h2000;
        i_sb.push_back('{mem_rd(iIADDR), 1'b0});
        d_sb.push_back('{mem_rd(iDADDR), 1'b0});
        prev_req = oBusREQ;
        grants = 0;
        for (int c = 0; c < 200 && grants < 10; c++) begin
            @(posedge iCLK); #1;
            if (oBusREQ && !prev_req) begin
                got = (oBusADDR >= 32'h2000);
                chk($sformatf("grant%0d", grants), 32'(got), 32'(exp_grant[grants]));
                $display("txn grant %0d -> %s addr=%h", grants, got ? "D" : "I", oBusADDR);
                grants++;
            end
            prev_req = oBusREQ;
            if (oDACK) begin
                iDADDR = iDADDR + 32'd4;
                d_sb.push_back('{mem_rd(iDADDR), 1'b0});
            end
            if (oIACK) begin
                iIADDR = iIADDR + 32'd4;
                i_sb.push_back('{mem_rd(iIADDR), 1'b0});
            end
        end
        chk("grant_count", 32'(grants), 32'd10);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge iCLK); #1;
            if (oIACK) begin
                seen = 1'b1;
                iIREQ = 1'b0; iDREQ = 1'b0;
                if (d_sb.size() != 0) void'(d_sb.pop_back());
            end
        end
        chk("starve_drain", 32'(seen), 32'd1);

        // Async reset while a data transaction is on the bus.
        @(posedge iCLK); #1;
        mem_wait = 1000;
        iDREQ = 1'b1; iDRW = 1'b1; iDADDR = 32'h400;
        repeat (3) begin @(posedge iCLK); #1; end
        chk("pre_rst_busreq", 32'(oBusREQ), 32'd1);
        chk("pre_rst_stall", 32'(oStallD), 32'd1);
        #3;
        iRST = 1'b0;
        #1;
        chk("rst_busreq_now", 32'(oBusREQ), 32'd0);
        chk("rst_ddata_now", oDDATA, 32'h0);
        iDREQ = 1'b0;
        @(posedge iCLK); #1;
        iRST = 1'b1;
        ddata_m = 32'h0;
        bad = 1'b0;
        repeat (5) begin
            @(posedge iCLK); #1;
            if (oBusREQ || oDACK || oIACK) bad = 1'b1;
        end
        chk("post_rst_quiet", 32'(bad), 32'd0);
        $display("txn async reset during BUS_D");

`ifdef ARB_TIMEOUT_EN
        @(posedge iCLK); #1;
        mem_wait = 1000;
        iDREQ = 1'b1; iDRW = 1'b1; iDADDR = 32'h500;
        d_sb.push_back('{32'h0, 1'b1});
        seen = 1'b0; lat = 0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(posedge iCLK); #1;
            if (oDACK) begin seen = 1'b1; lat = n; end
        end
        chk("to_ack_seen", 32'(seen), 32'd1);
        chk("to_latency", 32'(lat), 32'd16);
        iDREQ = 1'b0;
        force_ack = 1'b1;
        @(posedge iCLK); #1;
        force_ack = 1'b0;
        chk("to_late_ack", 32'({oBusREQ, oDACK, oIACK, oBusERR}), 32'h0);
        $display("txn timeout abort latency=%0d", lat);
`endif

        repeat (3) @(posedge iCLK);
        #1;
        chk("sb_i_empty", 32'(i_sb.size()), 32'd0);
        chk("sb_d_empty", 32'(d_sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
